// File: rtl/instr_mem_if.sv
// Fetch and program-load bus between the mini CPU front end and the
// instruction memory responder.
interface instr_mem_if;
   logic        REQ;
   logic [15:0] ADDR;
   logic [15:0] RDATA;
   logic        VALID;
   logic        ERR;
   logic        BUSY;
   logic        WR_EN;
   logic [15:0] WR_ADDR;
   logic [15:0] WR_DATA;

   modport master (
      output REQ, ADDR, WR_EN, WR_ADDR, WR_DATA,
      input  RDATA, VALID, ERR, BUSY
   );

   modport slave (
      input  REQ, ADDR, WR_EN, WR_ADDR, WR_DATA,
      output RDATA, VALID, ERR, BUSY
   );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: captures a fetch address, waits WAIT_CYC extra
// cycles, then returns the stored word with a one-cycle VALID pulse.
module instr_mem_responder #(
   parameter int DEPTH    = 256,
   parameter int WAIT_CYC = 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   instr_mem_if.slave    bus
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);
   localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYC);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [3:0]  cnt_r;
   logic [3:0]  cnt_s;
   logic [15:0] addr_r;
   logic        accept_s;
   logic        done_s;
   logic        addr_ok_s;
   logic [15:0] rd_word_s;
   logic [15:0] rdata_r;
   logic        valid_r;
   logic        err_r;
   logic        busy_r;
   logic [15:0] mem_r [DEPTH];

   // Full 16-bit compare so high addresses never alias onto low words.
   function automatic logic in_range(input logic [15:0] a);
      return ({1'b0, a} < DEPTH_L);
   endfunction

   // Program-load write port; memory has no reset and accepts writes in any state.
   always_ff @(posedge CLK) begin
      if (bus.WR_EN && in_range(bus.WR_ADDR)) begin
         mem_r[bus.WR_ADDR[AW-1:0]] <= bus.WR_DATA;
      end
   end

   // Read-side lookup of the captured address.
   always_comb begin
      addr_ok_s = in_range(addr_r);
      rd_word_s = 16'h0000;
      if (addr_ok_s) begin
         rd_word_s = mem_r[addr_r[AW-1:0]];
      end else begin
         rd_word_s = 16'h0000;
      end
   end

   // Next-state logic for the IDLE/READ sequencer.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      accept_s = 1'b0;
      done_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.REQ) begin
               accept_s = 1'b1;
               cnt_s    = WAIT_L;
               state_s  = ST_READ;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_READ: begin
            if (cnt_r != 4'd0) begin
               cnt_s   = cnt_r - 4'd1;
               state_s = ST_READ;
            end else begin
               done_s  = 1'b1;
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // State and output registers; the memory read above sees pre-edge contents,
   // which gives read-before-write on a completion-edge collision.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         addr_r  <= 16'h0000;
         rdata_r <= 16'h0000;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (accept_s) begin
            addr_r <= bus.ADDR;
         end
         if (done_s) begin
            rdata_r <= rd_word_s;
         end
         valid_r <= done_s;
         err_r   <= done_s & ~addr_ok_s;
         busy_r  <= (state_s == ST_READ);
      end
   end

   assign bus.RDATA = rdata_r;
   assign bus.VALID = valid_r;
   assign bus.ERR   = err_r;
   assign bus.BUSY  = busy_r;

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Instruction-memory responder for the mini CPU. It is the memory side of the fetch interface: it accepts a fetch address (the MAR value) with a request strobe, waits a configurable number of cycles, then returns the 16-bit instruction word (the OUT_MEMORY value) with a one-cycle valid pulse. A separate write port lets the testbench or boot loader fill program memory before and during execution.

Parameters:
DEPTH, 256, number of 16-bit words; valid addresses are 0..DEPTH-1; range 1..65536.
WAIT_CYC, 1, extra wait cycles inserted before data return; range 0..15; held in a 4-bit counter.

Ports:
CLK  input  1  clock, all state updates on the rising edge.
RST_N  input  1  asynchronous, active-low reset.
REQ  input  1  fetch request; sampled only while BUSY=0.
ADDR  input  16  fetch address; captured on the accepting edge.
RDATA  output  16  instruction word; registered.
VALID  output  1  one-cycle pulse; RDATA is valid while VALID=1.
ERR  output  1  pulses together with VALID when the captured address was >= DEPTH.
BUSY  output  1  high while a read is in progress; registered.
WR_EN  input  1  program-load write enable.
WR_ADDR  input  16  program-load address.
WR_DATA  input  16  program-load data.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State = IDLE, counter = 0, captured address = 0.
  - RDATA = 16'h0000, VALID = 0, ERR = 0, BUSY = 0.
  - Memory array contents are NOT reset.
- FSM states are IDLE and READ.
- IDLE:
  - If REQ=1 on an edge: capture addr_q = ADDR, cnt = WAIT_CYC, state -> READ, BUSY -> 1.
  - Otherwise remain in IDLE.
- READ, at each edge:
  - If cnt != 0: cnt decrements and the state holds.
  - If cnt == 0: RDATA <- mem[addr_q] (or 16'h0000 if addr_q >= DEPTH), VALID <- 1, ERR <- (addr_q >= DEPTH), BUSY <- 0, state -> IDLE.
- VALID and ERR are cleared on every edge that is not a read-completion edge. They are never high for two consecutive cycles.
- RDATA holds its last value until the next completion.
- Latency: REQ accepted at edge k gives VALID=1 in the cycle after edge k+1+WAIT_CYC. With WAIT_CYC=0, the data appears one cycle after acceptance.
- Throughput: REQ is ignored while BUSY=1 and is not queued. The requester must hold or re-assert REQ.
  - Back-to-back acceptance is possible on the completion+1 edge.
  - Minimum request period is WAIT_CYC+2 cycles.
- ADDR changes after the accepting edge have no effect on an in-flight read.
- Write port:
  - WR_EN=1 at an edge writes mem[WR_ADDR] <= WR_DATA when WR_ADDR < DEPTH.
  - Out-of-range writes are silently dropped, with no ERR pulse.
  - Writes are accepted in any state, including during a read.
- Read/write collision: if a write to addr_q occurs on the completion edge, RDATA returns the OLD contents (read-before-write). A write on an earlier wait edge is visible to the read.
- Reset mid-read: the in-flight transaction is discarded and no VALID is produced after reset release.
- Address comparison uses the full 16 bits; no wrap-around or aliasing.

Test Plan:
- Reset, then write 16'hA5A5 to address 3. With WAIT_CYC=1, pulse REQ with ADDR=3 at edge k -> VALID=1 and RDATA=16'hA5A5 after edge k+2, ERR=0, BUSY=1 for exactly 2 cycles.
- WAIT_CYC=0, REQ held high continuously over addresses 0..3 preloaded with 1,2,3,4 -> VALID pulses every 2 cycles, RDATA sequence 1,2,3,4, never two consecutive VALID cycles.
- DEPTH=256, REQ with ADDR=16'h0100 -> VALID=1, ERR=1, RDATA=16'h0000. A write to 16'h0100 leaves mem[0] unchanged.
- Change ADDR from 5 to 6 one cycle after acceptance, with mem[5]=16'h1111 and mem[6]=16'h2222 -> RDATA=16'h1111.
- Write 16'hBEEF to addr_q on the completion edge, where old contents are 16'h1234 -> RDATA=16'h1234. A following read of the same address returns 16'hBEEF.
- Assert RST_N=0 during READ with WAIT_CYC=3 -> BUSY, VALID and ERR go to 0 immediately, no VALID after release, and previously written memory still reads back correctly.
